// File: rtl/branch_sequencer_if.sv
// ----------------------------------------------------------------------------
// branch_sequencer_if
//
// Purpose:
//   Bundles the signals that run between the branch sequencer and the rest of
//   the rv32 pipeline (decode, ALU, fetch, pipeline control). clk and rst are
//   not part of the bundle.
//
// Signal summary:
//   br_valid / br_ready        decode -> sequencer request handshake
//   br_type, br_pc, br_imm     branch request payload
//   alu_valid                  ALU compare flags valid this cycle
//   alu_neg_flag, alu_zero_flag ALU compare flags
//   resolve_valid/_taken       one-cycle resolution pulse and outcome
//   redirect_valid / _ready    sequencer -> fetch redirect handshake
//   redirect_pc                redirect target
//   stall, flush               pipeline hold / squash controls
//
// Modports:
//   master : the pipeline side (drives requests, ALU flags, redirect_ready)
//   slave  : the branch sequencer itself
// ----------------------------------------------------------------------------
interface branch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              br_valid;
    logic              br_ready;
    logic [3:0]        br_type;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] br_imm;

    logic              alu_valid;
    logic              alu_neg_flag;
    logic              alu_zero_flag;

    logic              resolve_valid;
    logic              resolve_taken;

    logic              redirect_valid;
    logic              redirect_ready;
    logic [ADDR_W-1:0] redirect_pc;

    logic              stall;
    logic              flush;

    modport master (
        output br_valid,
        output br_type,
        output br_pc,
        output br_imm,
        output alu_valid,
        output alu_neg_flag,
        output alu_zero_flag,
        output redirect_ready,
        input  br_ready,
        input  resolve_valid,
        input  resolve_taken,
        input  redirect_valid,
        input  redirect_pc,
        input  stall,
        input  flush
    );

    modport slave (
        input  br_valid,
        input  br_type,
        input  br_pc,
        input  br_imm,
        input  alu_valid,
        input  alu_neg_flag,
        input  alu_zero_flag,
        input  redirect_ready,
        output br_ready,
        output resolve_valid,
        output resolve_taken,
        output redirect_valid,
        output redirect_pc,
        output stall,
        output flush
    );
endinterface

// File: rtl/branch_sequencer.sv
// ----------------------------------------------------------------------------
// branch_sequencer
//
// Purpose:
//   Multi-cycle controller that resolves conditional branches for the rv32
//   core. A branch request from decode is accepted in IDLE, the sequencer then
//   waits for the ALU compare flags, evaluates the condition, pulses a resolve
//   indication and, when taken, redirects fetch through a valid/ready
//   handshake followed by a fixed-length flush window. stall is held for the
//   whole time a branch is outstanding.
//
// Parameters:
//   ADDR_W       width of PC, immediate and redirect target
//   FLUSH_CYCLES number of cycles flush is high after an accepted redirect
//                (0 = no flush window at all)
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  branch_sequencer_if.slave, see the interface for the signal list
//
// Branch type encoding (br_type):
//   0 none, 1 eq (zero), 2 ne (!zero), 3 lt (neg), 4 gt (!neg && !zero),
//   5..15 none
// ----------------------------------------------------------------------------
module branch_sequencer #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    branch_sequencer_if.slave   bus
);

    // ------------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVAL     = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_e;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_EQ   = 4'd1,
        BR_NE   = 4'd2,
        BR_LT   = 4'd3,
        BR_GT   = 4'd4
    } br_type_e;

    // The counter only ever holds FLUSH_CYCLES-1 down to 0, and it still needs
    // at least one bit when the flush window is disabled.
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LOAD =
        (FLUSH_CYCLES > 0) ? CNT_W'(FLUSH_CYCLES - 1) : '0;

    // ------------------------------------------------------------------------
    // Condition evaluation
    // ------------------------------------------------------------------------
    function automatic logic is_branch(input logic [3:0] t);
        return (t >= 4'd1) && (t <= 4'd4);
    endfunction

    // gt is strict: a result that is both negative and zero (not physically
    // meaningful, but possible on the flag wires) must not take the branch.
    function automatic logic branch_taken(
        input br_type_e t,
        input logic     neg,
        input logic     zero
    );
        logic taken;
        taken = 1'b0;
        case (t)
            BR_EQ:   taken = zero;
            BR_NE:   taken = !zero;
            BR_LT:   taken = neg;
            BR_GT:   taken = !neg && !zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_e            state_q,         state_d;
    br_type_e          br_type_q,       br_type_d;
    logic [ADDR_W-1:0] target_q,        target_d;
    logic [CNT_W-1:0]  flush_cnt_q,     flush_cnt_d;
    logic              resolve_valid_q, resolve_valid_d;
    logic              resolve_taken_q, resolve_taken_d;

    logic              eval_taken;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of every other flop; blocking here would create
    // order-dependent simulation and a mismatch against synthesis.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            br_type_q       <= BR_NONE;
            target_q        <= '0;
            flush_cnt_q     <= '0;
            resolve_valid_q <= 1'b0;
            resolve_taken_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            br_type_q       <= br_type_d;
            target_q        <= target_d;
            flush_cnt_q     <= flush_cnt_d;
            resolve_valid_q <= resolve_valid_d;
            resolve_taken_q <= resolve_taken_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------------
    assign eval_taken = branch_taken(br_type_q, bus.alu_neg_flag, bus.alu_zero_flag);

    // NOTE: every signal written in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d         = state_q;
        br_type_d       = br_type_q;
        target_d        = target_q;
        flush_cnt_d     = flush_cnt_q;
        resolve_valid_d = 1'b0;
        resolve_taken_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // br_ready is 1 in IDLE, so br_valid alone completes the
                // handshake. Non-branch types are consumed without leaving
                // IDLE; alu_valid is meaningless here and not looked at.
                if (bus.br_valid && is_branch(bus.br_type)) begin
                    br_type_d = br_type_e'(bus.br_type);
                    target_d  = bus.br_pc + bus.br_imm;   // wraps mod 2^ADDR_W
                    state_d   = ST_EVAL;
                end
            end

            ST_EVAL: begin
                // Resolve pulse and the REDIRECT state appear on the same
                // edge, so resolve_valid and redirect_valid rise together.
                if (bus.alu_valid) begin
                    resolve_valid_d = 1'b1;
                    resolve_taken_d = eval_taken;
                    state_d         = eval_taken ? ST_REDIRECT : ST_IDLE;
                end
            end

            ST_REDIRECT: begin
                if (bus.redirect_ready) begin
                    if (FLUSH_CYCLES > 0) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_FLUSH: begin
                // Counter is loaded with FLUSH_CYCLES-1 and the state exits on
                // the cycle it reads 0, giving exactly FLUSH_CYCLES flush cycles.
                if (flush_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // redirect_pc reads the latched target directly; it only changes on a
    // request acceptance in IDLE, so it is stable for the whole REDIRECT wait.
    always_comb begin
        bus.br_ready       = (state_q == ST_IDLE);
        bus.stall          = (state_q != ST_IDLE);
        bus.redirect_valid = (state_q == ST_REDIRECT);
        bus.flush          = (state_q == ST_FLUSH);
        bus.resolve_valid  = resolve_valid_q;
        bus.resolve_taken  = resolve_taken_q;
        bus.redirect_pc    = target_q;
    end

    // ------------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------------
    // A stalled redirect must keep its request and target until fetch accepts.
    redirect_hold_a : assert property (
        @(posedge clk) disable iff (rst)
        (bus.redirect_valid && !bus.redirect_ready && !rst)
            |=> (bus.redirect_valid && $stable(bus.redirect_pc))
    );

    // The resolve indication is strictly a single-cycle pulse.
    resolve_pulse_a : assert property (
        @(posedge clk) disable iff (rst)
        (bus.resolve_valid && !rst) |=> !bus.resolve_valid
    );

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Multi-cycle controller that sequences conditional-branch resolution for the rv32 core.
- Accepts a branch request from decode and waits for the ALU compare result.
- Evaluates the branch condition using the team's branch_type encoding, then issues a redirect to fetch through a valid/ready handshake.
- Drives pipeline stall and flush while the branch is outstanding.

Parameters:
- ADDR_W, 32, width of PC, immediate and redirect target.
- FLUSH_CYCLES, 2, cycles flush stays high after an accepted redirect; 0 is legal and means no flush.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- br_valid  input  1  decode presents a branch request
- br_ready  output  1  sequencer can accept a request
- br_type  input  4  branch type: 0 = none, 1 = eq (zero), 2 = ne (!zero), 3 = lt (neg), 4 = gt (!neg && !zero), 5..15 = none
- br_pc  input  ADDR_W  PC of the branch instruction
- br_imm  input  ADDR_W  sign-extended branch offset
- alu_valid  input  1  ALU flags valid this cycle
- alu_neg_flag  input  1  ALU negative flag
- alu_zero_flag  input  1  ALU zero flag
- resolve_valid  output  1  one-cycle pulse: branch resolved
- resolve_taken  output  1  outcome qualified by resolve_valid
- redirect_valid  output  1  redirect request to fetch
- redirect_ready  input  1  fetch accepts redirect
- redirect_pc  output  ADDR_W  redirect target
- stall  output  1  hold upstream stages
- flush  output  1  squash wrong-path instructions

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- States: IDLE, EVAL, REDIRECT, FLUSH.
- On reset the state goes to IDLE at the next clk edge and all registers clear.
  - br_ready = 1.
  - resolve_valid, resolve_taken, redirect_valid, stall, flush = 0.
  - redirect_pc = 0.
  - Flush counter = 0.
- Reset asserted in any state aborts the operation. No redirect or flush is emitted afterwards.
- br_ready = (state == IDLE). stall = (state != IDLE). redirect_valid = (state == REDIRECT). flush = (state == FLUSH).
- IDLE:
  - The request is accepted when br_valid && br_ready.
  - br_type 1..4: latch type, latch target = br_pc + br_imm (mod 2^ADDR_W, overflow discarded), go to EVAL.
  - br_type 0 or 5..15: the request is consumed, state stays IDLE, no resolve pulse.
  - alu_valid is ignored in IDLE.
- EVAL:
  - Wait indefinitely for alu_valid.
  - On the cycle alu_valid = 1, sample the flags and evaluate the latched type.
  - The next cycle, resolve_valid = 1 for exactly one cycle, with resolve_taken = the result.
  - Taken: go to REDIRECT, with redirect_pc = the latched target.
  - Not taken: go to IDLE.
  - Type 4 with neg = 1 and zero = 1 is not taken.
- REDIRECT:
  - redirect_valid and redirect_pc are held stable until redirect_ready = 1.
  - On handshake: if FLUSH_CYCLES > 0, go to FLUSH and load the counter with FLUSH_CYCLES − 1; otherwise go to IDLE.
  - redirect_ready while not in REDIRECT is ignored.
- FLUSH:
  - flush = 1 every cycle in this state. The counter decrements each cycle; at 0, go to IDLE.
  - flush is high for exactly FLUSH_CYCLES consecutive cycles.
- br_valid while not in IDLE is not accepted. Decode must hold the request; stall covers this.
- Back-to-back requests are allowed:
  - A branch can be accepted on the first IDLE cycle after FLUSH.
  - A branch can be accepted on the first IDLE cycle after a not-taken resolve.
- Latency:
  - Acceptance to resolve_valid = (cycles waiting for alu_valid) + 1.
  - Resolve to redirect_valid = 0 cycles; they go high on the same edge.

Test Plan:
- beq, taken, no backpressure: br_type = 1, br_pc = 0x100, br_imm = 0x20; alu_valid on the cycle after acceptance with zero = 1; redirect_ready = 1.
  - resolve_taken = 1.
  - redirect_valid high for 1 cycle with redirect_pc = 0x120.
  - flush high for exactly 2 cycles, then br_ready = 1.
- bne, not taken: br_type = 2, zero = 1.
  - resolve_valid pulse with resolve_taken = 0.
  - No redirect and no flush.
  - stall drops the cycle after resolve.
- blt, taken, with backpressure and a wrapping target: br_type = 3, neg = 1, redirect_ready low for 3 cycles; br_pc = 0xFFFFFFF8, br_imm = 0x10.
  - redirect_valid held 4 cycles with redirect_pc = 0x00000008, stable throughout.
- bgt truth table: br_type = 4 with (neg, zero) = (0,0), (1,0), (0,1), (1,1).
  - Outcomes: taken only for (0,0); the other three are not taken.
- Non-branch types and ALU wait: br_type = 0, then 7.
  - Both consumed in IDLE, no stall, no resolve pulse.
  - Separately, br_type = 1 with alu_valid withheld 10 cycles: stall is held and resolve_valid stays 0 until alu_valid arrives.
- Reset mid-operation: rst = 1 for 1 cycle while in REDIRECT, and again while in FLUSH.
  - Next cycle: IDLE, br_ready = 1, all other outputs 0.
  - No residual flush.
